// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch (F) and data (D) requesters
//
// Purpose: grants one of two req/grant/resp requesters per transaction, drives
// the main-memory read/write port for READ_LATENCY cycles, and returns read data
// with a one-cycle resp_valid pulse.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   f_req/f_addr              fetch request and address
//   f_grant/f_resp_valid      fetch accept pulse, fetch response pulse
//   f_rdata                   fetch read data (held until next F read response)
//   d_req/d_we/d_addr/d_wdata data request, write flag, address, write data
//   d_grant/d_resp_valid      data accept pulse, data response pulse
//   d_rdata                   data read data (held until next D read response)
//   mem_*                     main-memory read/write port
//   busy                      high whenever the arbiter is not idle
module mem_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_req,
  input  logic [WIDTH-1:0] f_addr,
  output logic             f_grant,
  output logic             f_resp_valid,
  output logic [WIDTH-1:0] f_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_grant,
  output logic             d_resp_valid,
  output logic [WIDTH-1:0] d_rdata,
  output logic [WIDTH-1:0] mem_read_address,
  input  logic [WIDTH-1:0] mem_read_data,
  output logic [WIDTH-1:0] mem_write_address,
  output logic [WIDTH-1:0] mem_write_data,
  output logic             mem_write_enable,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  state_t           r_state;
  logic             r_last_d;   // 1 = D owned the port last; F wins the next tie
  logic             r_owner_d;  // owner of the access in flight
  logic [3:0]       r_count;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic             r_we;
  logic             r_mem_we;
  logic             r_f_resp;
  logic             r_d_resp;
  logic [WIDTH-1:0] r_f_rdata;
  logic [WIDTH-1:0] r_d_rdata;

  logic w_idle;
  logic w_f_win;
  logic w_d_win;

  // Grants are combinational so a request is accepted in the cycle it is seen.
  // Suppressed during reset so an aborting cycle never hands out a grant.
  assign w_idle  = (r_state == S_IDLE) && !rst;
  assign w_f_win = w_idle && f_req && (!d_req || r_last_d);
  assign w_d_win = w_idle && d_req && (!f_req || !r_last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last_d  <= 1'b1;
      r_owner_d <= 1'b0;
      r_count   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_mem_we  <= 1'b0;
      r_f_resp  <= 1'b0;
      r_d_resp  <= 1'b0;
      r_f_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_f_resp <= 1'b0;
      r_d_resp <= 1'b0;
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_f_win || w_d_win) begin
            r_owner_d <= w_d_win;
            r_last_d  <= w_d_win;
            r_addr    <= w_d_win ? d_addr : f_addr;
            r_wdata   <= w_d_win ? d_wdata : '0;
            r_we      <= w_d_win && d_we;
            // Write strobe lives only in the first ACCESS cycle.
            r_mem_we  <= w_d_win && d_we;
            r_count   <= LAT_M1;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_count == 4'd0) begin
            if (!r_we) begin
              if (r_owner_d) r_d_rdata <= mem_read_data;
              else           r_f_rdata <= mem_read_data;
            end
            if (r_owner_d) r_d_resp <= 1'b1;
            else           r_f_resp <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign f_grant           = w_f_win;
  assign d_grant           = w_d_win;
  assign f_resp_valid      = r_f_resp;
  assign d_resp_valid      = r_d_resp;
  assign f_rdata           = r_f_rdata;
  assign d_rdata           = r_d_rdata;
  // Address/data registers only change on a grant, so they hold outside ACCESS.
  assign mem_read_address  = r_addr;
  assign mem_write_address = r_addr;
  assign mem_write_data    = r_wdata;
  assign mem_write_enable  = r_mem_we;
  assign busy              = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter (latency 1 and 3 instances)
module tb_mem_port_arbiter;

  logic        clk;
  logic [1:0]  rst;
  logic [1:0]  f_req, f_grant, f_resp_valid;
  logic [1:0]  d_req, d_we, d_grant, d_resp_valid;
  logic [1:0]  mem_write_enable, busy;
  logic [31:0] f_addr [2];
  logic [31:0] f_rdata [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic [31:0] d_rdata [2];
  logic [31:0] mem_read_address [2];
  logic [31:0] mem_read_data [2];
  logic [31:0] mem_write_address [2];
  logic [31:0] mem_write_data [2];

  typedef struct packed {
    logic        inst;
    logic        isd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [2][256];
  logic [31:0] exp_frd [2];
  logic [31:0] exp_drd [2];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt [2];
  logic [31:0] we_addr [2];
  logic [31:0] we_data [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem [256];

    mem_port_arbiter #(.WIDTH(32), .READ_LATENCY(g == 0 ? 1 : 3)) u_dut (
      .clk               (clk),
      .rst               (rst[g]),
      .f_req             (f_req[g]),
      .f_addr            (f_addr[g]),
      .f_grant           (f_grant[g]),
      .f_resp_valid      (f_resp_valid[g]),
      .f_rdata           (f_rdata[g]),
      .d_req             (d_req[g]),
      .d_we              (d_we[g]),
      .d_addr            (d_addr[g]),
      .d_wdata           (d_wdata[g]),
      .d_grant           (d_grant[g]),
      .d_resp_valid      (d_resp_valid[g]),
      .d_rdata           (d_rdata[g]),
      .mem_read_address  (mem_read_address[g]),
      .mem_read_data     (mem_read_data[g]),
      .mem_write_address (mem_write_address[g]),
      .mem_write_data    (mem_write_data[g]),
      .mem_write_enable  (mem_write_enable[g]),
      .busy              (busy[g])
    );

    // Main-memory model: contents restored on reset, read path combinational.
    always @(posedge clk) begin
      if (rst[g]) begin
        for (int i = 0; i < 256; i++) mem[i] <= {24'hA5A5A5, 8'(i)};
        mem[5] <= 32'hDEADBEEF;
      end else if (mem_write_enable[g]) begin
        mem[mem_write_address[g][7:0]] <= mem_write_data[g];
      end
    end
    assign mem_read_data[g] = mem[mem_read_address[g][7:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(input int g);
    for (int i = 0; i < 256; i++) model[g][i] = {24'hA5A5A5, 8'(i)};
    model[g][5] = 32'hDEADBEEF;
    exp_frd[g] = '0;
    exp_drd[g] = '0;
  endtask

  // Expected response computed from the bench's own memory model at grant time.
  task automatic push_exp(input int g, input bit isd, input bit we,
                          input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.inst = 1'(g);
    e.isd  = isd;
    if (isd && we) begin
      model[g][a[7:0]] = wd;
      e.data = exp_drd[g];
    end else if (isd) begin
      exp_drd[g] = model[g][a[7:0]];
      e.data = exp_drd[g];
    end else begin
      exp_frd[g] = model[g][a[7:0]];
      e.data = exp_frd[g];
    end
    sb.push_back(e);
  endtask

  task automatic sb_check(input int g, input bit isd, input logic [31:0] obs);
    exp_t e;
    check("resp_expected", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("resp_owner", {30'd0, 1'(g), isd}, {30'd0, e.inst, e.isd});
      check("resp_data", obs, e.data);
    end
  endtask

  // Issues one request, waits (bounded) for its grant, drops req the cycle after.
  task automatic access(input int g, input bit isd, input bit we,
                        input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    if (isd) begin
      d_req[g] = 1'b1; d_we[g] = we; d_addr[g] = a; d_wdata[g] = wd;
    end else begin
      f_req[g] = 1'b1; f_addr[g] = a;
    end
    #1;
    while (!(isd ? d_grant[g] : f_grant[g]) && n < 40) begin
      tick();
      n++;
    end
    check("grant_timeout", 32'(n < 40), 32'd1);
    push_exp(g, isd, we, a, wd);
    tick();
    if (isd) d_req[g] = 1'b0;
    else     f_req[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    while (busy[g] && n < 40) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(n < 40), 32'd1);
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (mem_write_enable[g] === 1'b1) begin
        we_cnt[g]++;
        we_addr[g] = mem_write_address[g];
        we_data[g] = mem_write_data[g];
      end
      if (f_resp_valid[g] === 1'b1) sb_check(g, 1'b0, f_rdata[g]);
      if (d_resp_valid[g] === 1'b1) sb_check(g, 1'b1, d_rdata[g]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, ngr, both, we0;
    logic [3:0]  ord;

    rst = 2'b11;
    f_req = '0; d_req = '0; d_we = '0;
    for (int g = 0; g < 2; g++) begin
      f_addr[g] = '0; d_addr[g] = '0; d_wdata[g] = '0;
      we_cnt[g] = 0; we_addr[g] = '0; we_data[g] = '0;
      model_reset(g);
    end
    tick();
    tick();
    rst = 2'b00;

    // Reset state
    check("rst_busy", {30'd0, busy}, 32'd0);
    check("rst_grants", {28'd0, f_grant, d_grant}, 32'd0);
    check("rst_resp", {28'd0, f_resp_valid, d_resp_valid}, 32'd0);
    check("rst_f_rdata", f_rdata[0], 32'd0);
    check("rst_d_rdata", d_rdata[0], 32'd0);
    check("rst_mem_raddr", mem_read_address[0], 32'd0);
    check("rst_mem_wdata", mem_write_data[0], 32'd0);
    check("rst_mem_we", {30'd0, mem_write_enable}, 32'd0);

    // Single F read, latency 1
    f_req[0] = 1'b1; f_addr[0] = 32'd5;
    #1;
    check("t1_f_grant", {31'd0, f_grant[0]}, 32'd1);
    check("t1_d_grant", {31'd0, d_grant[0]}, 32'd0);
    push_exp(0, 1'b0, 1'b0, 32'd5, 32'd0);
    tick();
    f_req[0] = 1'b0;
    check("t1_mem_raddr", mem_read_address[0], 32'd5);
    check("t1_busy_access", {31'd0, busy[0]}, 32'd1);
    check("t1_no_resp_yet", {31'd0, f_resp_valid[0]}, 32'd0);
    tick();
    check("t1_f_resp", {31'd0, f_resp_valid[0]}, 32'd1);
    check("t1_f_rdata", f_rdata[0], 32'hDEADBEEF);
    tick();
    check("t1_busy_low", {31'd0, busy[0]}, 32'd0);
    check("t1_resp_one_cycle", {31'd0, f_resp_valid[0]}, 32'd0);

    // D write then D read
    we0 = we_cnt[0];
    access(0, 1'b1, 1'b1, 32'h10, 32'h12345678);
    wait_idle(0);
    check("t2_we_cycles", 32'(we_cnt[0] - we0), 32'd1);
    check("t2_we_addr", we_addr[0], 32'h10);
    check("t2_we_data", we_data[0], 32'h12345678);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0);
    wait_idle(0);
    check("t2_d_rdata", d_rdata[0], 32'h12345678);
    check("t2_f_rdata_kept", f_rdata[0], 32'hDEADBEEF);

    // Both requesters held for four transactions: round-robin F,D,F,D
    f_req[0] = 1'b1; f_addr[0] = 32'h20;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h30;
    n = 0; ngr = 0; both = 0; ord = '0;
    while (ngr < 4 && n < 60) begin
      #1;
      if (f_grant[0] && d_grant[0]) both++;
      if (f_grant[0]) begin
        ord = {ord[2:0], 1'b0}; ngr++;
        push_exp(0, 1'b0, 1'b0, 32'h20, 32'h0);
      end
      if (d_grant[0]) begin
        ord = {ord[2:0], 1'b1}; ngr++;
        push_exp(0, 1'b1, 1'b0, 32'h30, 32'h0);
      end
      tick();
      n++;
    end
    f_req[0] = 1'b0; d_req[0] = 1'b0;
    wait_idle(0);
    check("t3_grants", 32'(ngr), 32'd4);
    check("t3_order", {28'd0, ord}, 32'h5);
    check("t3_both_grant", 32'(both), 32'd0);

    // Latency 3: response exactly 4 cycles after grant, address stable
    f_req[1] = 1'b1; f_addr[1] = 32'd7;
    #1;
    check("t4_f_grant", {31'd0, f_grant[1]}, 32'd1);
    push_exp(1, 1'b0, 1'b0, 32'd7, 32'd0);
    tick();
    f_req[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t4_mem_raddr", mem_read_address[1], 32'd7);
      check("t4_no_early_resp", {31'd0, f_resp_valid[1]}, 32'd0);
      tick();
    end
    check("t4_f_resp", {31'd0, f_resp_valid[1]}, 32'd1);
    tick();
    check("t4_idle", {31'd0, busy[1]}, 32'd0);

    // Reset in second ACCESS cycle of a latency-3 D read
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'd9;
    #1;
    check("t5_d_grant", {31'd0, d_grant[1]}, 32'd1);
    tick();
    d_req[1] = 1'b0;
    tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    model_reset(1);
    check("t5_busy", {31'd0, busy[1]}, 32'd0);
    check("t5_d_resp", {31'd0, d_resp_valid[1]}, 32'd0);
    check("t5_d_rdata", d_rdata[1], 32'd0);
    check("t5_f_rdata", f_rdata[1], 32'd0);
    check("t5_mem_raddr", mem_read_address[1], 32'd0);
    check("t5_mem_we", {31'd0, mem_write_enable[1]}, 32'd0);
    f_req[1] = 1'b1; f_addr[1] = 32'd5;
    #1;
    check("t5_f_grant_now", {31'd0, f_grant[1]}, 32'd1);
    push_exp(1, 1'b0, 1'b0, 32'd5, 32'd0);
    tick();
    f_req[1] = 1'b0;
    wait_idle(1);
    repeat (3) tick();
    check("t5_no_stray_resp", {31'd0, d_resp_valid[1]}, 32'd0);

    // D request withdrawn while an F access is busy
    we0 = we_cnt[0];
    access(0, 1'b0, 1'b0, 32'h40, 32'h0);
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h44; d_wdata[0] = 32'h00000BAD;
    #1;
    check("t6_no_grant_access", {31'd0, d_grant[0]}, 32'd0);
    tick();
    check("t6_no_grant_resp", {31'd0, d_grant[0]}, 32'd0);
    d_req[0] = 1'b0;
    tick();
    check("t6_no_grant_idle", {31'd0, d_grant[0]}, 32'd0);
    check("t6_busy", {31'd0, busy[0]}, 32'd0);
    check("t6_no_write", 32'(we_cnt[0] - we0), 32'd0);
    access(0, 1'b0, 1'b0, 32'h44, 32'h0);
    wait_idle(0);
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the instruction-fetch requester (F) and the load/store requester (D) of the cpu.
- Each requester uses a req/grant/resp handshake. The arbiter latches the winning request, drives the memory read/write port, and returns read data with a one-cycle response pulse.
- Replaces the hard-wired tie-off of the memory address and write lines in cpu; the stage sequencer raises req instead of driving memory directly.

Parameters:
- WIDTH, 32, address and data width.
- READ_LATENCY, 1, cycles from address presentation to valid mem_read_data; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- f_req  in  1  fetch request, held until f_grant.
- f_addr  in  WIDTH  fetch address.
- f_grant  out  1  one-cycle pulse; F request accepted this cycle.
- f_resp_valid  out  1  one-cycle pulse; f_rdata valid.
- f_rdata  out  WIDTH  fetch read data.
- d_req  in  1  data request, held until d_grant.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  WIDTH  data address.
- d_wdata  in  WIDTH  write data.
- d_grant  out  1  one-cycle pulse; D request accepted.
- d_resp_valid  out  1  one-cycle pulse; read data valid or write complete.
- d_rdata  out  WIDTH  data read data.
- mem_read_address  out  WIDTH  to main_memory.
- mem_read_data  in  WIDTH  from main_memory.
- mem_write_address  out  WIDTH  to main_memory.
- mem_write_data  out  WIDTH  to main_memory.
- mem_write_enable  out  1  to main_memory.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset response:
  - state = IDLE; last_owner = D, so F wins the first tie.
  - All grant and resp_valid outputs = 0; f_rdata = d_rdata = 0.
  - All mem_* outputs = 0; latched request registers = 0.
- States:
  - IDLE: grant is combinational in the same cycle req is seen. Winner's addr, we (0 for F) and wdata are latched at the edge. owner <- winner; count <- READ_LATENCY-1; go to ACCESS.
  - ACCESS: mem_read_address and mem_write_address = latched addr. mem_write_data = latched wdata.
    - mem_write_enable = latched we, only in the first ACCESS cycle.
    - At the last ACCESS cycle (count == 0), if the access is a read, mem_read_data is registered into owner's rdata; go to RESP.
    - Otherwise count decrements.
  - RESP: owner's resp_valid = 1 for exactly one cycle; go to IDLE. No grant is issued in RESP.
- Outside ACCESS, mem_write_enable = 0 and mem addresses hold their last value.
- Arbitration in IDLE:
  - Only one req high: grant it.
  - Both high: grant the requester that is not last_owner (round-robin).
  - last_owner updates on every grant.
- Latency: grant at cycle T; ACCESS T+1..T+READ_LATENCY; resp_valid at T+READ_LATENCY+1. Sustained throughput is one access per READ_LATENCY+2 cycles.
- rdata registers hold their value until the next read response to the same requester. A write never alters d_rdata.
- Handshake rules:
  - A requester must hold req and its payload stable until grant.
  - Dropping req before grant withdraws the request with no side effects.
  - req may be raised again in the RESP cycle; it is serviced from the following IDLE cycle.
- Requests seen during ACCESS or RESP are not granted; they wait.
- Reset mid-operation aborts the access:
  - An in-flight write whose first ACCESS cycle has already occurred is not rolled back.
  - No resp_valid is issued for the aborted access.
- Address width is passed through unchanged; no address translation or alignment checks.

Test Plan:
- Single F read, READ_LATENCY=1, memory[5]=0xDEADBEEF: f_req, f_addr=5 at T -> f_grant at T, mem_read_address=5 at T+1, f_resp_valid with f_rdata=0xDEADBEEF at T+2, busy low at T+3.
- D write then D read, addr 0x10, data 0x12345678 -> mem_write_enable high exactly one cycle with mem_write_address=0x10; subsequent read returns d_rdata=0x12345678; f_rdata unchanged.
- Simultaneous f_req and d_req held for 4 transactions -> grants in order F, D, F, D; no cycle with both grants high.
- READ_LATENCY=3, F read -> f_resp_valid exactly 4 cycles after f_grant; mem_read_address stable for 3 cycles.
- rst asserted in the second ACCESS cycle of a D read (READ_LATENCY=3) -> next cycle state IDLE, all outputs 0, no d_resp_valid; the next f_req is granted immediately.
- d_req dropped before grant while an F access is busy -> no d_grant and no memory write occurs.
